deserializador_fifo: RTL and testbench
======================================

Name: deserializador_fifo

Overview:
Parametrised successor to the 8-bit deserializer. It shifts serial bits qualified by write_in into WIDTH-bit words. Completed words are queued in a DEPTH-entry output FIFO, so serial intake continues while the consumer has not yet acknowledged. It sits between the serial link front end and the parallel consumer, and uses the same write_in/ack_in/data_ready handshake.

Parameters:
WIDTH, 8, data bits per word (min 2)
DEPTH, 4, FIFO entries (power of 2, min 2)
MSB_FIRST, 1, 1: first received bit lands in data_out[WIDTH-1]; 0: first bit lands in data_out[0]

Ports:
clk_100KHz  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  1  serial data bit, sampled when write_in=1
write_in  input  1  bit-valid strobe, one bit per cycle while high
ack_in  input  1  consumer pops FIFO head
status_out  output  1  1 = block accepts bits (FIFO not full)
data_out  output  WIDTH  FIFO head word; 0 when FIFO empty
data_ready  output  1  1 = FIFO non-empty
count_out  output  $clog2(DEPTH+1)  words currently queued
overflow_out  output  1  one-cycle pulse: bit dropped because FIFO full
parity_err_out  output  1  one-cycle pulse on parity mismatch (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears shift register, bit counter, FIFO pointers and count; partial word discarded.
  - Outputs: status_out=1, data_ready=0, data_out=0, count_out=0, overflow_out=0, parity_err_out=0.
  - Reset released mid-word: reception restarts at bit 0.
- States (derived from bit counter and count):
  - IDLE: bit_cnt=0.
  - SHIFT: 0<bit_cnt<WIDTH.
  - STALL: count=DEPTH. Entered only at a word boundary; bit_cnt is 0 in STALL.
- Accept rule: a bit is accepted on a rising edge with write_in=1 and status_out=1. status_out = (count<DEPTH) is combinational from registered count.
- Shift order:
  - MSB_FIRST=1: shift left, new bit into LSB.
  - MSB_FIRST=0: shift right, new bit into MSB.
- Push:
  - On the edge accepting the WIDTH-th bit, the assembled word (including that bit) is written to the FIFO tail and bit_cnt returns to 0.
  - data_ready rises the following cycle, so word latency is 1 cycle after the last bit edge.
  - Back-to-back words need no idle cycle.
- Pop: ack_in=1 with data_ready=1 advances the head; the next word (or 0 if empty) is visible the next cycle. ack_in with data_ready=0 is ignored.
- Push and pop on the same edge: count unchanged; both pointers advance.
- Full:
  - write_in=1 while status_out=0: bit dropped, shift state unchanged, overflow_out=1 for the next cycle.
  - An ack_in on that same edge frees a slot; status_out rises the next cycle, and the dropped bit is not recovered.
- Pointers wrap modulo DEPTH; count_out saturates logically at DEPTH (never exceeds).
- data_in is ignored when write_in=0; write_in held high accepts one bit per cycle.

Optional Feature:
- Macro: DESERIALIZADOR_PARITY_CHECK_EN.
- Defined:
  - Each word is followed by one even-parity bit; bit_cnt runs 0..WIDTH.
  - The word is pushed only on the edge accepting the parity bit, and only if XOR(data bits, parity bit)=0.
  - On mismatch: word discarded, no push, parity_err_out=1 for one cycle, bit_cnt returns to 0.
  - STALL is checked per bit exactly as without parity.
- Undefined: WIDTH bits per word as above; parity_err_out is tied to 0 (port always present).

Test Plan:
- Reset, WIDTH=8, MSB_FIRST=1, send 1,0,1,0,1,1,0,1 -> data_ready=1 one cycle after 8th bit, data_out=8'hAD, count_out=1; ack_in pulse -> data_ready=0, data_out=0.
- MSB_FIRST=0, same bit stream -> data_out=8'hB5.
- Send 5 words (8'h01..8'h05) with no ack, DEPTH=4:
  - After 4th word: status_out=0, count_out=4.
  - Bits of 5th word: each write_in pulses overflow_out, count stays 4.
  - Four acks return 01,02,03,04 in order.
- FIFO full, assert ack_in and write_in on the same edge -> bit dropped with overflow_out=1; next cycle status_out=1, count_out=3.
- Assert reset low after 3 bits of a word, then send a full 8'h3C -> data_out=8'h3C (no residue), count_out=1.
- With DESERIALIZADOR_PARITY_CHECK_EN:
  - 8'hAD + parity 1 -> pushed.
  - 8'hAD + parity 0 -> parity_err_out pulse, count_out unchanged.

Source files
------------

// File: rtl/deserializador_fifo.sv
`default_nettype none
// ============================================================================
// Module      : deserializador_fifo
// Description : Serial-to-parallel converter. Words of WIDTH bits are queued
//               in a DEPTH-entry FIFO using the write_in/ack_in/data_ready
//               handshake. Define DESERIALIZADOR_PARITY_CHECK_EN to expect a
//               trailing even-parity bit after every word.
// Revision    : 1.0 - initial release
// ============================================================================
module deserializador_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk_100KHz,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       write_in,
    input  logic                       ack_in,
    output logic                       status_out,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_ready,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       overflow_out,
    output logic                       parity_err_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int BIT_W = $clog2(WIDTH+1);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_shift;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_parity_err;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_accept;
    logic             w_pop;
    logic             w_push;
    logic             w_perr;
    logic             w_shift_en;
    logic             w_cnt_wrap;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_push_word;

    assign status_out = (r_count < c_DEPTH);
    assign w_accept   = write_in & status_out;
    assign data_ready = (r_count != '0);
    assign w_pop      = ack_in & data_ready;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_next = (r_shift << 1) | WIDTH'(data_in);
        end else begin : g_lsb_first
            assign w_shift_next = (r_shift >> 1) | {data_in, {(WIDTH-1){1'b0}}};
        end
    endgenerate

`ifdef DESERIALIZADOR_PARITY_CHECK_EN
    // Position WIDTH carries the parity bit; the word is complete in r_shift.
    localparam logic [BIT_W-1:0] c_LAST = BIT_W'(WIDTH);
    assign w_cnt_wrap  = (r_bit_cnt == c_LAST);
    assign w_shift_en  = ~w_cnt_wrap;
    assign w_push      = w_accept & w_cnt_wrap & ~((^r_shift) ^ data_in);
    assign w_perr      = w_accept & w_cnt_wrap &  ((^r_shift) ^ data_in);
    assign w_push_word = r_shift;
`else
    localparam logic [BIT_W-1:0] c_LAST = BIT_W'(WIDTH-1);
    assign w_cnt_wrap  = (r_bit_cnt == c_LAST);
    assign w_shift_en  = 1'b1;
    assign w_push      = w_accept & w_cnt_wrap;
    assign w_perr      = 1'b0;
    assign w_push_word = w_shift_next;
`endif

    always_ff @(posedge clk_100KHz or negedge reset) begin
        if (!reset) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_bit_cnt <= w_cnt_wrap ? '0 : r_bit_cnt + 1'b1;
                if (w_shift_en) begin
                    r_shift <= w_shift_next;
                end
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow   <= write_in & ~status_out;
            r_parity_err <= w_perr;
        end
    end

    // Storage needs no reset: empty entries are masked on data_out.
    always_ff @(posedge clk_100KHz) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    assign data_out       = data_ready ? r_mem[r_rd_ptr] : '0;
    assign count_out      = r_count;
    assign overflow_out   = r_overflow;
    assign parity_err_out = r_parity_err;

endmodule
`default_nettype wire

// File: tb/tb_deserializador_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_deserializador_fifo
// Description : Self-checking bench; a queue-based model of the word stream
//               is compared with two DUTs (MSB-first and LSB-first) each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializador_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef DESERIALIZADOR_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NBITS = WIDTH + (PAR ? 1 : 0);

    logic             clk_100KHz = 1'b0;
    logic             reset      = 1'b0;
    logic             data_in    = 1'b0;
    logic             write_in   = 1'b0;
    logic             ack_in     = 1'b0;

    logic             status_m, ready_m, ovf_m, perr_m;
    logic [WIDTH-1:0] data_m;
    logic [2:0]       count_m;
    logic             status_l, ready_l, ovf_l, perr_l;
    logic [WIDTH-1:0] data_l;
    logic [2:0]       count_l;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_100KHz = ~clk_100KHz;

    deserializador_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
        .clk_100KHz(clk_100KHz), .reset(reset), .data_in(data_in),
        .write_in(write_in), .ack_in(ack_in), .status_out(status_m),
        .data_out(data_m), .data_ready(ready_m), .count_out(count_m),
        .overflow_out(ovf_m), .parity_err_out(perr_m));

    deserializador_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
        .clk_100KHz(clk_100KHz), .reset(reset), .data_in(data_in),
        .write_in(write_in), .ack_in(ack_in), .status_out(status_l),
        .data_out(data_l), .data_ready(ready_l), .count_out(count_l),
        .overflow_out(ovf_l), .parity_err_out(perr_l));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: list of received bits, two word queues (one per bit order).
    logic             bits[$];
    logic [WIDTH-1:0] q_m[$];
    logic [WIDTH-1:0] q_l[$];
    logic             e_ovf  = 1'b0;
    logic             e_perr = 1'b0;

    always @(posedge clk_100KHz or negedge reset) begin
        if (!reset) begin
            bits.delete();
            q_m.delete();
            q_l.delete();
            e_ovf  = 1'b0;
            e_perr = 1'b0;
        end else begin
            automatic bit full = (q_m.size() == DEPTH);
            automatic logic [WIDTH-1:0] wm = '0;
            automatic logic [WIDTH-1:0] wl = '0;
            automatic logic par = 1'b0;
            e_ovf  = write_in && full;
            e_perr = 1'b0;
            if (ack_in && q_m.size() != 0) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
            end
            if (write_in && !full) begin
                bits.push_back(data_in);
                if (bits.size() == NBITS) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        wm[WIDTH-1-i] = bits[i];
                        wl[i]         = bits[i];
                    end
                    for (int i = 0; i < NBITS; i++) par = par ^ bits[i];
                    if (!PAR || par == 1'b0) begin
                        q_m.push_back(wm);
                        q_l.push_back(wl);
                    end else begin
                        e_perr = 1'b1;
                    end
                    bits.delete();
                end
            end
        end
    end

    always @(negedge clk_100KHz) begin
        automatic int n = q_m.size();
        chk("status_m", status_m, n < DEPTH);
        chk("status_l", status_l, n < DEPTH);
        chk("ready_m",  ready_m,  n != 0);
        chk("ready_l",  ready_l,  n != 0);
        chk("count_m",  count_m,  n);
        chk("count_l",  count_l,  n);
        chk("data_m",   data_m,   n != 0 ? q_m[0] : '0);
        chk("data_l",   data_l,   n != 0 ? q_l[0] : '0);
        chk("ovf_m",    ovf_m,    e_ovf);
        chk("ovf_l",    ovf_l,    e_ovf);
        chk("perr_m",   perr_m,   e_perr);
        chk("perr_l",   perr_l,   e_perr);
    end

    task automatic cyc(input logic w, input logic d, input logic a);
        write_in = w;
        data_in  = d;
        ack_in   = a;
        @(posedge clk_100KHz);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH-1; i >= 0; i--) cyc(1'b1, w[i], 1'b0);
`ifdef DESERIALIZADOR_PARITY_CHECK_EN
        cyc(1'b1, ^w, 1'b0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("rst_status", status_m, 1);
        chk("rst_ready",  ready_m,  0);
        chk("rst_data",   data_m,   0);
        chk("rst_count",  count_m,  0);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);

        send_word(8'hAD);
        chk("ad_ready", ready_m, 1);
        chk("ad_data",  data_m,  8'hAD);
        chk("b5_data",  data_l,  8'hB5);
        chk("ad_count", count_m, 1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("ack_ready", ready_m, 0);
        chk("ack_data",  data_m,  0);

        for (int k = 1; k <= 4; k++) send_word(WIDTH'(k));
        chk("full_status", status_m, 0);
        chk("full_count",  count_m,  4);
        for (int i = 0; i < NBITS; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk("drop_ovf",   ovf_m,   1);
            chk("drop_count", count_m, 4);
        end
        cyc(1'b0, 1'b0, 1'b0);
        chk("ovf_clear", ovf_m, 0);
        for (int k = 1; k <= 4; k++) begin
            chk("pop_order", data_m, k);
            cyc(1'b0, 1'b0, 1'b1);
        end
        chk("drained", ready_m, 0);

        for (int k = 1; k <= 4; k++) send_word(WIDTH'(k * 8'h11));
        cyc(1'b1, 1'b1, 1'b1);
        chk("sim_ovf",    ovf_m,    1);
        chk("sim_status", status_m, 1);
        chk("sim_count",  count_m,  3);
        chk("sim_head",   data_m,   8'h22);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1);

        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        write_in = 1'b0;
        reset    = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        send_word(8'h3C);
        chk("rst_mid_data",  data_m,  8'h3C);
        chk("rst_mid_count", count_m, 1);
        cyc(1'b0, 1'b0, 1'b1);

`ifdef DESERIALIZADOR_PARITY_CHECK_EN
        for (int i = WIDTH-1; i >= 0; i--) cyc(1'b1, 1'(8'hAD >> i), 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("par_ok_count", count_m, 1);
        chk("par_ok_data",  data_m,  8'hAD);
        chk("par_ok_err",   perr_m,  0);
        for (int i = WIDTH-1; i >= 0; i--) cyc(1'b1, 1'(8'hAD >> i), 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("par_bad_err",   perr_m,  1);
        chk("par_bad_count", count_m, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("par_err_pulse", perr_m, 0);
        cyc(1'b0, 1'b0, 1'b1);
`endif
        cyc(1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
